// File: rtl/seq_div_16bit_if.sv
// rtl/seq_div_16bit_if.sv - request/result bundle for the 16-bit signed sequential divider
interface seq_div_16bit_if;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Quot;
   logic [15:0] Rem;
   logic        busy;
   logic        done;
   logic        Error;

   modport master (
      output start, A, B,
      input  Quot, Rem, busy, done, Error
   );

   modport slave (
      input  start, A, B,
      output Quot, Rem, busy, done, Error
   );
endinterface

// File: rtl/seq_div_16bit.sv
// rtl/seq_div_16bit.sv - 16-bit signed restoring divider, one quotient bit per cycle
module seq_div_16bit (
   input  logic            clk,
   input  logic            rst,
   seq_div_16bit_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        sign_a;
   logic        sign_b;
   logic [15:0] dvd;
   logic [15:0] part;
   logic [15:0] mag_b;
   logic [15:0] quot;
   logic [15:0] rem;
   logic        err;
   logic        done_r;

   logic [15:0] mag_a_in;
   logic [15:0] mag_b_in;
   logic [16:0] trial;
   logic [15:0] q_neg;
   logic [15:0] r_neg;
   logic        neg_q;

   // dvd starts as |A| and fills with quotient bits as the dividend shifts out
   always_comb begin
      mag_a_in = bus.A[15] ? (~bus.A + 16'd1) : bus.A;
      mag_b_in = bus.B[15] ? (~bus.B + 16'd1) : bus.B;
      trial    = {part, dvd[15]} - {1'b0, mag_b};
      q_neg    = ~dvd + 16'd1;
      r_neg    = ~part + 16'd1;
      neg_q    = sign_a ^ sign_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dvd    <= 16'd0;
         part   <= 16'd0;
         mag_b  <= 16'd0;
         quot   <= 16'd0;
         rem    <= 16'd0;
         err    <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sign_a <= bus.A[15];
                  sign_b <= bus.B[15];
                  dvd    <= mag_a_in;
                  mag_b  <= mag_b_in;
                  part   <= 16'd0;
                  cnt    <= 4'd0;
                  if (bus.B == 16'd0) begin
                     quot  <= 16'hFFFF;
                     rem   <= bus.A;
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               dvd  <= {dvd[14:0], ~trial[16]};
               part <= trial[16] ? {part[14:0], dvd[15]} : trial[15:0];
               cnt  <= cnt + 4'd1;
               if (cnt == 4'd15)
                  state <= SIGN;
            end
            SIGN: begin
               // a positive 32768 quotient only arises from 8000h / FFFFh
               if (!neg_q && dvd == 16'h8000) begin
                  quot <= 16'h8000;
                  rem  <= 16'd0;
                  err  <= 1'b1;
               end else begin
                  quot <= neg_q  ? q_neg : dvd;
                  rem  <= sign_a ? r_neg : part;
                  err  <= 1'b0;
               end
               state <= DONE;
            end
            default: begin
               done_r <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_r;
   assign bus.Quot  = quot;
   assign bus.Rem   = rem;
   assign bus.Error = err;
endmodule

// File: tb/tb_seq_div_16bit.sv
// tb/tb_seq_div_16bit.sv - randomized self-checking bench for seq_div_16bit
module tb_seq_div_16bit;
   logic clk;
   logic rst;
   logic chk_en;
   int   n_tests;
   int   n_fail;

   seq_div_16bit_if bus ();

   seq_div_16bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result straight from signed integer arithmetic
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic e);
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (b == 16'd0) begin
         q = 16'hFFFF; r = a; e = 1'b1;
      end else if (sa == -32768 && sb == -1) begin
         q = 16'h8000; r = 16'h0000; e = 1'b1;
      end else begin
         q = 16'(sa / sb); r = 16'(sa % sb); e = 1'b0;
      end
   endfunction

   // Transaction-level model: cycles left until done, and the visible result
   int          m_left;
   logic        m_done;
   logic [15:0] m_q, m_r, p_q, p_r;
   logic        m_e, p_e;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0;
         m_q = 16'd0; m_r = 16'd0; m_e = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left == 0) begin
            if (bus.start === 1'b1) begin
               ref_div(bus.A, bus.B, p_q, p_r, p_e);
               if (bus.B == 16'd0) begin
                  m_q = p_q; m_r = p_r; m_e = p_e;
                  m_left = 1;
               end else begin
                  m_left = 18;
               end
            end
         end else begin
            m_left--;
            if (m_left == 1) begin
               m_q = p_q; m_r = p_r; m_e = p_e;
            end
            if (m_left == 0)
               m_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc busy",  {31'd0, bus.busy},  {31'd0, (m_left != 0)});
         chk("cyc done",  {31'd0, bus.done},  {31'd0, m_done});
         chk("cyc Quot",  {16'd0, bus.Quot},  {16'd0, m_q});
         chk("cyc Rem",   {16'd0, bus.Rem},   {16'd0, m_r});
         chk("cyc Error", {31'd0, bus.Error}, {31'd0, m_e});
      end
   end

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ee, input int elat, input string tag);
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.A = a; bus.B = b;
      @(negedge clk);
      bus.start = 1'b0; bus.A = 16'($urandom); bus.B = 16'($urandom);
      wait_done(lat);
      chk({tag, " latency"}, lat, elat);
      chk({tag, " Quot"}, {16'd0, bus.Quot}, {16'd0, eq});
      chk({tag, " Rem"}, {16'd0, bus.Rem}, {16'd0, er});
      chk({tag, " Error"}, {31'd0, bus.Error}, {31'd0, ee});
      @(negedge clk);
      chk({tag, " done width"}, {31'd0, bus.done}, 32'd0);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.done === 1'b1) n++;
      end
   endtask

   initial begin
      logic [15:0] q, r;
      logic        e;
      int          lat, n;

      n_tests = 0; n_fail = 0; chk_en = 1'b0;
      bus.start = 1'b0; bus.A = 16'd0; bus.B = 16'd0;

      ref_div(16'h0064, 16'h0007, q, r, e);
      chk("model 100/7", {q, r}, 32'h000E_0002);
      ref_div(16'hFFF9, 16'h0002, q, r, e);
      chk("model -7/2", {q, r}, 32'hFFFD_FFFF);
      ref_div(16'h8000, 16'h0001, q, r, e);
      chk("model 8000/1", {15'd0, e, q}, 32'h0000_8000);

      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset outputs", {bus.Quot, bus.Rem}, 32'd0);
      chk("reset flags", {29'd0, bus.busy, bus.done, bus.Error}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      do_div(16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 18, "100/7");
      do_div(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18, "-7/2");
      do_div(16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18, "7/-2");
      do_div(16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1,  "5/0");
      do_div(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 18, "8000/-1");
      do_div(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18, "8000/1");

      // start pulse while busy is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.A = 16'h0064; bus.B = 16'h0007;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0001;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
      chk("busy start latency", lat, 13);
      chk("busy start result", {bus.Quot, bus.Rem}, 32'h000E_0002);
      count_done(25, n);
      chk("busy start single done", n, 0);

      // start held high re-accepts in the done cycle
      @(negedge clk);
      bus.start = 1'b1; bus.A = 16'h0064; bus.B = 16'h0007;
      @(negedge clk);
      wait_done(lat);
      chk("held start first", lat, 18);
      @(negedge clk);
      wait_done(lat);
      chk("held start second", lat, 18);
      bus.start = 1'b0;
      repeat (22) @(negedge clk);

      // asynchronous reset mid-CALC
      @(negedge clk);
      bus.start = 1'b1; bus.A = 16'h0064; bus.B = 16'h0007;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort outputs", {bus.Quot, bus.Rem}, 32'd0);
      chk("abort flags", {29'd0, bus.busy, bus.done, bus.Error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_done(25, n);
      chk("abort no done", n, 0);
      do_div(16'h0010, 16'h0004, 16'h0004, 16'h0000, 1'b0, 18, "16/4");

      // random traffic, checked every cycle against the model
      repeat (4000) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       begin bus.A = 16'($urandom); bus.B = 16'h0000; end
            1:       begin bus.A = 16'h8000;      bus.B = 16'hFFFF; end
            2:       begin bus.A = 16'($urandom); bus.B = 16'($urandom_range(0, 3)) - 16'd1; end
            3:       begin bus.A = 16'h8000;      bus.B = 16'($urandom); end
            default: begin bus.A = 16'($urandom); bus.B = 16'($urandom); end
         endcase
      end
      bus.start = 1'b0;
      repeat (25) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
